// File: rtl/xbee_pkg.sv
// Shared definitions for the XBee UART transmit scheduler.
// Frame state encoding, UART word size, default bit-period divider
// and the even-parity helper used when XBEE_TX_PARITY_EN is defined.
package xbee_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int DEFAULT_BAUD_DIV = 5208;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Even parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/xbee_tx_scheduler_if.sv
// Requester-side bus of the XBee transmit scheduler.
// master: the packet builders (drive bytes), slave: the scheduler.
interface xbee_tx_scheduler_if
    import xbee_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]                ReqValid;
    logic [UART_DATA_BITS*N_REQ-1:0] ReqData;
    logic [N_REQ-1:0]                ReqLast;
    logic [N_REQ-1:0]                ReqReady;
    logic [N_REQ-1:0]                Grant;

    modport master (
        output ReqValid, ReqData, ReqLast,
        input  ReqReady, Grant
    );

    modport slave (
        input  ReqValid, ReqData, ReqLast,
        output ReqReady, Grant
    );
endinterface

// File: rtl/xbee_tx_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter: grants the first set request at or above
// ptr_i, wrapping to index 0. Purely combinational.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         grant_o
);

    logic found_s;

    // Two passes: indices from the pointer upward, then the wrapped lower part
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found_s && req_i[j] && (j >= int'(ptr_i))) begin
                grant_o[j] = 1'b1;
                found_s    = 1'b1;
            end else begin
                grant_o[j] = grant_o[j];
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found_s && req_i[j] && (j < int'(ptr_i))) begin
                grant_o[j] = 1'b1;
                found_s    = 1'b1;
            end else begin
                grant_o[j] = grant_o[j];
            end
        end
    end

endmodule

// File: rtl/xbee_tx_scheduler.sv
// XBee UART transmit scheduler: arbitrates N_REQ byte streams onto one
// serial Tx line as 8N1 frames, holding the grant for a whole packet.
// Optional feature macro: XBEE_TX_PARITY_EN adds an even-parity bit (8E1).
module xbee_tx_scheduler
    import xbee_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic                Clk,
    input  logic                Reset,
    xbee_tx_scheduler_if.slave  bus,
    output logic                Tx,
    output logic                Busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

    state_e                    state_q;
    logic                      tx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [BAUD_W-1:0]         baud_q;
    logic [BIT_W-1:0]          bit_q;
    logic                      lock_q;
    logic [IDX_W-1:0]          owner_q;
    logic [IDX_W-1:0]          ptr_q;
    logic [N_REQ-1:0]          grant_hold_q;
`ifdef XBEE_TX_PARITY_EN
    logic                      par_q;
`endif

    logic [N_REQ-1:0]          arb_grant_s;
    logic [N_REQ-1:0]          grant_s;
    logic [N_REQ-1:0]          ready_s;
    logic                      hs_s;
    logic                      baud_end_s;
    logic [IDX_W-1:0]          hs_idx_s;
    logic [UART_DATA_BITS-1:0] hs_data_s;
    logic                      hs_last_s;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i   (bus.ReqValid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s)
    );

    // Current owner: locked packet owner or fresh arbitration in IDLE, held grant during a frame
    always_comb begin
        if (!Reset) begin
            grant_s = '0;
        end else if (state_q == ST_IDLE) begin
            if (lock_q) begin
                grant_s = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
            end else begin
                grant_s = arb_grant_s;
            end
        end else begin
            grant_s = grant_hold_q;
        end
    end

    // Ready only while idle; a handshake needs the granted requester to be valid
    always_comb begin
        ready_s    = (state_q == ST_IDLE) ? grant_s : '0;
        hs_s       = |(bus.ReqValid & ready_s);
        baud_end_s = (baud_q == BAUD_LAST);
    end

    // One-hot mux of the granted requester's index, byte and last flag
    always_comb begin
        hs_idx_s  = '0;
        hs_data_s = '0;
        hs_last_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            hs_idx_s  = hs_idx_s  | (grant_s[i] ? IDX_W'(i) : '0);
            hs_data_s = hs_data_s | ({UART_DATA_BITS{grant_s[i]}}
                                     & bus.ReqData[i*UART_DATA_BITS +: UART_DATA_BITS]);
            hs_last_s = hs_last_s | (grant_s[i] & bus.ReqLast[i]);
        end
    end

    // Frame sequencer: accepts a byte, times each bit and drives the registered Tx line
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            tx_q         <= 1'b1;
            shift_q      <= '0;
            baud_q       <= '0;
            bit_q        <= '0;
            lock_q       <= 1'b0;
            owner_q      <= '0;
            ptr_q        <= '0;
            grant_hold_q <= '0;
`ifdef XBEE_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_s) begin
                        shift_q      <= hs_data_s;
                        baud_q       <= '0;
                        bit_q        <= '0;
                        grant_hold_q <= grant_s;
                        tx_q         <= 1'b0;
                        state_q      <= ST_START;
`ifdef XBEE_TX_PARITY_EN
                        par_q        <= even_parity(hs_data_s);
`endif
                        if (hs_last_s) begin
                            lock_q <= 1'b0;
                            ptr_q  <= (hs_idx_s == IDX_LAST) ? '0 : hs_idx_s + IDX_W'(1);
                        end else begin
                            lock_q  <= 1'b1;
                            owner_q <= hs_idx_s;
                        end
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
`ifdef XBEE_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`ifdef XBEE_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    baud_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Grant    = grant_s;
    assign bus.ReqReady = ready_s;
    assign Tx           = tx_q;
    assign Busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xbee_tx_scheduler.sv
// Self-checking bench for xbee_tx_scheduler (N_REQ=2, BAUD_DIV=4).
// A frame-level reference model predicts Grant/ReqReady/Tx/Busy every cycle;
// directed scenarios add hand-computed literal expectations.
module tb_xbee_tx_scheduler;

    localparam int N = 2;
    localparam int B = 4;
`ifdef XBEE_TX_PARITY_EN
    localparam int FB       = 11;
    localparam int EXP_LEN  = 44;
    localparam int A5_BIT9  = 0;
`else
    localparam int FB       = 10;
    localparam int EXP_LEN  = 40;
    localparam int A5_BIT9  = 1;
`endif
    localparam int FLEN = FB * B;

    logic Clk;
    logic Reset;
    logic Tx;
    logic Busy;

    xbee_tx_scheduler_if #(.N_REQ(N)) bus();

    xbee_tx_scheduler #(.N_REQ(N), .BAUD_DIV(B)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus),
        .Tx    (Tx),
        .Busy  (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [N-1:0] pop_s;

    // reference model state
    bit          m_in_frame;
    int          m_el;
    logic [10:0] m_bits;
    bit          m_lock;
    int          m_owner;
    int          m_ptr;
    logic [N-1:0] m_hold;

    int   hs_who[$];
    int   hs_cyc[$];
    logic txlog   [0:4095];
    logic busylog [0:4095];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (r == '0 && v[(p + k) % N]) r[(p + k) % N] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_cycle();
        logic [N-1:0] v, eg, er;
        logic et, eb;
        int i;
        logic [7:0] d;
        v = bus.ReqValid;
        if (Reset !== 1'b1) begin
            eg = '0; er = '0; et = 1'b1; eb = 1'b0;
            m_in_frame = 0; m_lock = 0; m_ptr = 0;
        end else if (m_in_frame) begin
            eg = m_hold; er = '0; eb = 1'b1; et = m_bits[m_el / B];
        end else begin
            eb = 1'b0; et = 1'b1;
            if (m_lock) begin
                eg = '0;
                eg[m_owner] = 1'b1;
            end else begin
                eg = rr_pick(v, m_ptr);
            end
            er = eg;
        end
        chk("grant", 32'(bus.Grant), 32'(eg));
        chk("ready", 32'(bus.ReqReady), 32'(er));
        chk("tx", 32'(Tx), 32'(et));
        chk("busy", 32'(Busy), 32'(eb));
        if (cyc < 4096) begin
            txlog[cyc]   = Tx;
            busylog[cyc] = Busy;
        end
        pop_s = '0;
        if (Reset === 1'b1) begin
            if (m_in_frame) begin
                m_el++;
                if (m_el == FLEN) m_in_frame = 0;
            end else if ((v & er) != '0) begin
                i = 0;
                for (int k = 0; k < N; k++) if (er[k]) i = k;
                d = bus.ReqData[i*8 +: 8];
                m_bits = '1;
                m_bits[0] = 1'b0;
                for (int k = 0; k < 8; k++) m_bits[k+1] = d[k];
`ifdef XBEE_TX_PARITY_EN
                m_bits[9] = ^d;
`endif
                m_in_frame = 1; m_el = 0; m_hold = eg;
                if (bus.ReqLast[i]) begin
                    m_lock = 0; m_ptr = (i + 1) % N;
                end else begin
                    m_lock = 1; m_owner = i;
                end
                pop_s[i] = 1'b1;
                hs_who.push_back(i);
                hs_cyc.push_back(cyc);
            end
        end
        cyc++;
    endtask

    task automatic drive();
        bus.ReqValid[0]   = (q0.size() != 0);
        bus.ReqData[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        bus.ReqLast[0]    = (q0.size() != 0) ? q0[0][8] : 1'b0;
        bus.ReqValid[1]   = (q1.size() != 0);
        bus.ReqData[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        bus.ReqLast[1]    = (q1.size() != 0) ? q1[0][8] : 1'b0;
    endtask

    task automatic step();
        @(negedge Clk);
        model_cycle();
        @(posedge Clk);
        #1;
        if (pop_s[0]) void'(q0.pop_front());
        if (pop_s[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (((q0.size() + q1.size()) != 0 || m_in_frame) && n < max) begin
            step();
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles", max);
        end
        step();
    endtask

    task automatic check_frame(input int k, input logic [7:0] d);
        int t;
        logic expb;
        t = hs_cyc[k];
        for (int b = 0; b < 9; b++) begin
            expb = (b == 0) ? 1'b0 : d[b-1];
            chk("frame_bit", 32'(txlog[t + 1 + b*B + B/2]), 32'(expb));
        end
    endtask

    task automatic busy_count(input int k, input int exp);
        int t, cnt;
        t = hs_cyc[k];
        cnt = 0;
        for (int c = t; c <= t + FLEN + 1; c++) if (busylog[c] === 1'b1) cnt++;
        chk("busy_len", 32'(cnt), 32'(exp));
    endtask

    initial begin
        int base;
        int zeros;
        Reset        = 1'b0;
        bus.ReqValid = '0;
        bus.ReqData  = '0;
        bus.ReqLast  = '0;
        m_in_frame = 0; m_el = 0; m_bits = '1; m_lock = 0; m_owner = 0; m_ptr = 0; m_hold = '0;
        run(3);
        chk("rst_tx", 32'(Tx), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_grant", 32'(bus.Grant), 32'd0);
        chk("rst_ready", 32'(bus.ReqReady), 32'd0);
        Reset = 1'b1;
        run(3);

        // single byte 0xA5 from requester 0
        q0.push_back({1'b1, 8'hA5});
        drive();
        drain(200);
        chk("s1_who", 32'(hs_who[0]), 32'd0);
        check_frame(0, 8'hA5);
        chk("s1_bit9", 32'(txlog[hs_cyc[0] + 1 + 9*B + 2]), 32'(A5_BIT9));
        busy_count(0, EXP_LEN);

        // pointer now at 1: requester 1 wins a simultaneous request
        base = hs_who.size();
        q0.push_back({1'b1, 8'h3C});
        q1.push_back({1'b1, 8'hC3});
        drive();
        drain(400);
        chk("ptr_first", 32'(hs_who[base]), 32'd1);
        chk("ptr_second", 32'(hs_who[base+1]), 32'd0);
        chk("ptr_gap", 32'(hs_cyc[base+1] - hs_cyc[base]), 32'(EXP_LEN + 1));

        // contention straight after reset
        Reset = 1'b0;
        run(2);
        Reset = 1'b1;
        run(2);
        base = hs_who.size();
        q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h22});
        drive();
        drain(400);
        chk("cont_first", 32'(hs_who[base]), 32'd0);
        chk("cont_second", 32'(hs_who[base+1]), 32'd1);
        chk("cont_gap", 32'(hs_cyc[base+1] - hs_cyc[base]), 32'(EXP_LEN + 1));
        check_frame(base + 1, 8'h22);

        // packet lock: three bytes of requester 0 before requester 1
        base = hs_who.size();
        q0.push_back({1'b0, 8'h01});
        q0.push_back({1'b0, 8'h02});
        q0.push_back({1'b1, 8'h03});
        q1.push_back({1'b1, 8'h04});
        drive();
        drain(800);
        chk("lock_b0", 32'(hs_who[base]), 32'd0);
        chk("lock_b1", 32'(hs_who[base+1]), 32'd0);
        chk("lock_b2", 32'(hs_who[base+2]), 32'd0);
        chk("lock_b3", 32'(hs_who[base+3]), 32'd1);
        check_frame(base + 2, 8'h03);

        // owner stall: requester 0 locks, goes quiet, requester 1 must wait
        base = hs_who.size();
        q0.push_back({1'b0, 8'h55});
        q1.push_back({1'b1, 8'h66});
        drive();
        run(EXP_LEN + 102);
        chk("stall_count", 32'(hs_who.size() - base), 32'd1);
        chk("stall_who", 32'(hs_who[base]), 32'd0);
        zeros = 0;
        for (int c = hs_cyc[base] + EXP_LEN + 1; c < cyc; c++) if (txlog[c] !== 1'b1) zeros++;
        chk("stall_line_idle", 32'(zeros), 32'd0);
        chk("stall_grant", 32'(bus.Grant), 32'd1);
        q0.push_back({1'b1, 8'h77});
        drive();
        drain(400);
        chk("stall_resume", 32'(hs_who[base+1]), 32'd0);
        chk("stall_then_r1", 32'(hs_who[base+2]), 32'd1);
        check_frame(base + 1, 8'h77);

        // reset in the middle of data bit 3
        base = hs_who.size();
        q0.push_back({1'b1, 8'hC3});
        drive();
        begin
            int n;
            n = 0;
            while (hs_who.size() == base && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL hs_timeout: no handshake within 50 cycles");
            end
        end
        run(17);
        chk("mid_busy", 32'(Busy), 32'd1);
        Reset = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(Tx), 32'd1);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_grant", 32'(bus.Grant), 32'd0);
        run(2);
        Reset = 1'b1;
        run(2);
        q0.push_back({1'b1, 8'h5A});
        drive();
        drain(200);
        check_frame(base + 1, 8'h5A);
        busy_count(base + 1, EXP_LEN);

`ifdef XBEE_TX_PARITY_EN
        // parity build: 0x07 has three ones, parity bit 1, 44-cycle frame
        base = hs_who.size();
        q0.push_back({1'b1, 8'h07});
        drive();
        drain(200);
        check_frame(base, 8'h07);
        chk("par_bit", 32'(txlog[hs_cyc[base] + 1 + 9*B + 2]), 32'd1);
        chk("par_stop", 32'(txlog[hs_cyc[base] + 1 + 10*B + 2]), 32'd1);
        busy_count(base, 44);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
